// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and helpers for the frame serializer.
//   state_t   - serializer states (IDLE, HI, LO, LCR, LLF, TCR, TLF)
//   ASCII_CR / ASCII_LF - line control characters
//   TERM_*    - encodings of the TERM_MODE parameter
//   nib2hex   - 4-bit nibble to uppercase ASCII hex character
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    LCR  = 3'd3,
    LLF  = 3'd4,
    TCR  = 3'd5,
    TLF  = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int TERM_NONE = 32'd0;
  localparam int TERM_CR   = 32'd1;
  localparam int TERM_CRLF = 32'd2;

  // 0-9 map to '0'-'9' (0x30 base); A-F map to 'A'-'F' (0x41 = 0x37 + 10)
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    if (nib < 4'd10) begin
      nib2hex = 8'h30 + {4'h0, nib};
    end else begin
      nib2hex = 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: latches a DATA_BYTES-wide word on i_stb and streams it
// MSB byte first as raw bytes or uppercase ASCII hex over a valid/ready
// handshake, with optional CR/LF line breaks and a frame terminator.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   i_data         - payload, byte 0 in the top 8 bits
//   i_stb, i_hex   - start request and mode (1 = hex), captured when idle
//   o_busy         - frame in progress
//   o_done         - one-cycle pulse after the last character transfers
//   o_drop         - one-cycle pulse when i_stb arrives while busy
//   o_byte/o_valid - character stream, i_ready accepts it
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int DATA_BYTES = 1000,
  parameter int LINE_BYTES = 0,
  parameter int TERM_MODE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] i_data,
  input  logic                    i_stb,
  input  logic                    i_hex,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_drop,
  output logic [7:0]              o_byte,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  // Divisor that is never zero; only used when LINE_BYTES != 0
  localparam int LB_SAFE = (LINE_BYTES == 0) ? 32'd1 : LINE_BYTES;

  state_t          state_r, state_s, adv_state_s;
  logic [DW-1:0]   shreg_r, shreg_s;
  logic            hex_r, hex_s;
  logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic            xfer_s, last_s, brk_s, done_s, drop_s;

  // Character shown while in a given state; the payload byte is always the
  // top byte of the shift register
  function automatic logic [7:0] char_of(input state_t st, input logic [7:0] top_byte,
                                         input logic hex_mode);
    case (st)
      HI:       char_of = hex_mode ? nib2hex(top_byte[7:4]) : top_byte;
      LO:       char_of = nib2hex(top_byte[3:0]);
      LCR, TCR: char_of = ASCII_CR;
      LLF, TLF: char_of = ASCII_LF;
      default:  char_of = 8'h00;
    endcase
  endfunction

  // Where to go once the current payload byte has fully transferred
  always_comb begin
    cnt_inc_s = cnt_r + CW'(1'b1);
    last_s    = (cnt_inc_s == CW'(DATA_BYTES));
    brk_s     = (LINE_BYTES != 0) && !last_s && ((32'(cnt_inc_s) % LB_SAFE) == 32'd0);
    if (brk_s) begin
      adv_state_s = LCR;
    end else if (last_s) begin
      adv_state_s = (TERM_MODE != TERM_NONE) ? TCR : IDLE;
    end else begin
      adv_state_s = HI;
    end
  end

  // Next-state, shift register, counter and pulse logic
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    hex_s   = hex_r;
    cnt_s   = cnt_r;
    xfer_s  = o_valid && i_ready;
    case (state_r)
      IDLE: begin
        if (i_stb) begin
          shreg_s = i_data;
          hex_s   = i_hex;
          cnt_s   = '0;
          state_s = HI;
        end else begin
          state_s = IDLE;
        end
      end
      HI, LO: begin
        if (xfer_s && (state_r == HI) && hex_r) begin
          state_s = LO;
        end else if (xfer_s) begin
          shreg_s = shreg_r << 4'd8;
          cnt_s   = cnt_inc_s;
          state_s = adv_state_s;
        end else begin
          state_s = state_r;
        end
      end
      LCR: begin
        if (xfer_s) state_s = LLF;
        else        state_s = LCR;
      end
      LLF: begin
        if (xfer_s) state_s = HI;
        else        state_s = LLF;
      end
      TCR: begin
        if (xfer_s) state_s = (TERM_MODE == TERM_CRLF) ? TLF : IDLE;
        else        state_s = TCR;
      end
      TLF: begin
        if (xfer_s) state_s = IDLE;
        else        state_s = TLF;
      end
      default: state_s = IDLE;
    endcase
    // Completion is the transfer that returns the FSM to IDLE
    done_s = (state_r != IDLE) && (state_s == IDLE);
    drop_s = i_stb && (state_r != IDLE);
  end

  // State and registered outputs; o_byte is precomputed from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= '0;
      hex_r   <= 1'b0;
      cnt_r   <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_drop  <= 1'b0;
      o_byte  <= 8'h00;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      hex_r   <= hex_s;
      cnt_r   <= cnt_s;
      o_busy  <= (state_s != IDLE);
      o_valid <= (state_s != IDLE);
      o_done  <= done_s;
      o_drop  <= drop_s;
      o_byte  <= char_of(state_s, shreg_s[DW-1 -: 8], hex_s);
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: two instances (4B no line breaks CR term; 4B line every
// 2 bytes CR/LF term). A queue model built from the framing rules is checked
// against every transfer; literal strings pin the model.
module tb_uart_frame_tx;

  localparam int LB0 = 0, TM0 = 1, LB1 = 2, TM1 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_w [2];
  logic        stb_w  [2];
  logic        hex_w  [2];
  logic        rdy_w  [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        drop_w [2];
  logic        valid_w[2];
  logic [7:0]  byte_w [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [2][$];
  logic [7:0] got_q [2][$];
  int         len_q [2][$];
  int         sent  [2];
  logic       hold  [2];
  logic [7:0] hold_b[2];

  always #5 clk = ~clk;

  uart_frame_tx #(.DATA_BYTES(4), .LINE_BYTES(LB0), .TERM_MODE(TM0)) u_a (
    .clk(clk), .rst(rst), .i_data(data_w[0]), .i_stb(stb_w[0]), .i_hex(hex_w[0]),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_drop(drop_w[0]), .o_byte(byte_w[0]),
    .o_valid(valid_w[0]), .i_ready(rdy_w[0]));

  uart_frame_tx #(.DATA_BYTES(4), .LINE_BYTES(LB1), .TERM_MODE(TM1)) u_b (
    .clk(clk), .rst(rst), .i_data(data_w[1]), .i_stb(stb_w[1]), .i_hex(hex_w[1]),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_drop(drop_w[1]), .o_byte(byte_w[1]),
    .o_valid(valid_w[1]), .i_ready(rdy_w[1]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    else return 8'h41 + 8'(n) - 8'd10;
  endfunction

  // Expected character stream of one frame, from the framing rules
  task automatic push_model(input int k, input logic [31:0] d, input bit hx);
    int lb, tm, n;
    logic [7:0] c;
    lb = (k == 0) ? LB0 : LB1;
    tm = (k == 0) ? TM0 : TM1;
    n  = 0;
    for (int b = 0; b < 4; b++) begin
      c = d[31 - 8*b -: 8];
      if (hx) begin
        exp_q[k].push_back(hexc(c[7:4]));
        exp_q[k].push_back(hexc(c[3:0]));
        n += 2;
      end else begin
        exp_q[k].push_back(c);
        n += 1;
      end
      if (lb != 0 && ((b + 1) % lb) == 0 && b != 3) begin
        exp_q[k].push_back(8'h0D);
        exp_q[k].push_back(8'h0A);
        n += 2;
      end
    end
    if (tm >= 1) begin exp_q[k].push_back(8'h0D); n += 1; end
    if (tm == 2) begin exp_q[k].push_back(8'h0A); n += 1; end
    len_q[k].push_back(n);
  endtask

  task automatic check_str(input int k, input string name, input string s);
    bit ok;
    ok = (got_q[k].size() == s.len());
    for (int i = 0; i < s.len() && i < got_q[k].size(); i++)
      if (got_q[k][i] != s[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d chars, want %0d chars \"%s\"", name, got_q[k].size(), s.len(), s);
    end
    got_q[k].delete();
  endtask

  // Called at posedge+1; request is captured at the following edge
  task automatic start(input int k, input logic [31:0] d, input bit hx);
    data_w[k] = d;
    hex_w[k]  = hx;
    stb_w[k]  = 1'b1;
    push_model(k, d, hx);
    @(posedge clk); #1;
    stb_w[k]  = 1'b0;
  endtask

  // Returns at posedge+1 of the o_done cycle
  task automatic wait_done(input int k, input bit thr);
    int n = 0;
    do begin
      @(posedge clk); #1;
      if (thr) rdy_w[k] = ($urandom_range(0, 9) < 3);
      n++;
    end while (!done_w[k] && n < 600);
    chk("wait_done_timeout", 32'(done_w[k]), 32'd1);
    rdy_w[k] = 1'b1;
  endtask

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hold[k] = 1'b0;
      end else begin
        if (busy_w[k] !== valid_w[k]) chk("busy_eq_valid", 32'(busy_w[k]), 32'(valid_w[k]));
        if (hold[k]) begin
          chk("hold_valid", 32'(valid_w[k]), 32'd1);
          chk("hold_byte", 32'(byte_w[k]), 32'(hold_b[k]));
        end
        if (valid_w[k] && rdy_w[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("extra_char", 32'(byte_w[k]), 32'hFFFF_FFFF);
          end else begin
            chk("stream_char", 32'(byte_w[k]), 32'(exp_q[k].pop_front()));
          end
          got_q[k].push_back(byte_w[k]);
          sent[k]++;
        end
        hold[k]   = valid_w[k] && !rdy_w[k];
        hold_b[k] = byte_w[k];
        if (done_w[k]) begin
          chk("done_idle", {30'd0, busy_w[k], valid_w[k]}, 32'd0);
          if (len_q[k].size() == 0) chk("done_spurious", 32'd1, 32'd0);
          else chk("done_frame_len", 32'(sent[k]), 32'(len_q[k].pop_front()));
          sent[k] = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_w[k] = 32'd0; stb_w[k] = 1'b0; hex_w[k] = 1'b0; rdy_w[k] = 1'b1;
      sent[k] = 0; hold[k] = 1'b0; hold_b[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_flags", {28'd0, busy_w[k], done_w[k], drop_w[k], valid_w[k]}, 32'd0);
      chk("reset_byte", 32'(byte_w[k]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: raw "HI!~\r"; i_stb cycle is cycle 0, o_done must occupy cycle 6
    start(0, 32'h4849217E, 1'b0);
    chk("t1_first_valid", {31'd0, valid_w[0]}, 32'd1);
    chk("t1_first_byte", 32'(byte_w[0]), 32'h48);
    n = 0;
    while (!done_w[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("t1_done_cycle", 32'(n + 1), 32'd6);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", {31'd0, done_w[0]}, 32'd0);
    check_str(0, "t1_raw_stream", "HI!~\r");

    // 2: hex uppercase
    start(0, 32'hDEAD000F, 1'b1);
    wait_done(0, 1'b0);
    check_str(0, "t2_hex_stream", "DEAD000F\r");

    // 3: line breaks every 2 bytes, CR/LF terminator, none after last byte
    start(1, 32'h01020304, 1'b1);
    wait_done(1, 1'b0);
    check_str(1, "t3_line_stream", "0102\r\n0304\r\n");

    // 4: throttled ready, same stream as unthrottled
    rdy_w[0] = 1'b0;
    start(0, 32'hDEAD000F, 1'b1);
    wait_done(0, 1'b1);
    check_str(0, "t4_throttled_stream", "DEAD000F\r");

    // 5: strobe while busy is dropped; strobe in o_done cycle is accepted
    start(0, 32'h41424344, 1'b0);
    data_w[0] = 32'h5A5A5A5A;
    stb_w[0]  = 1'b1;
    @(posedge clk); #1;
    stb_w[0]  = 1'b0;
    chk("t5_drop_pulse", {31'd0, drop_w[0]}, 32'd1);
    @(posedge clk); #1;
    chk("t5_drop_one_cycle", {31'd0, drop_w[0]}, 32'd0);
    wait_done(0, 1'b0);
    start(0, 32'h31323334, 1'b0);
    chk("t5_back_to_back_busy", {30'd0, busy_w[0], valid_w[0]}, 32'd3);
    chk("t5_back_to_back_byte", 32'(byte_w[0]), 32'h31);
    wait_done(0, 1'b0);
    check_str(0, "t5_streams", "ABCD\r1234\r");

    // 6: reset after the third transfer aborts the frame without o_done
    start(0, 32'h41424344, 1'b0);
    n = 0;
    while (sent[0] < 3 && n < 40) begin @(posedge clk); #1; n++; end
    chk("t6_reach_third", 32'(sent[0]), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_reset_flags", {28'd0, busy_w[0], done_w[0], drop_w[0], valid_w[0]}, 32'd0);
    chk("t6_reset_byte", 32'(byte_w[0]), 32'd0);
    rst = 1'b0;
    exp_q[0].delete(); len_q[0].delete(); got_q[0].delete(); sent[0] = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("t6_no_done", {30'd0, done_w[0], valid_w[0]}, 32'd0);
    end
    start(0, 32'h5A594241, 1'b0);
    wait_done(0, 1'b0);
    check_str(0, "t6_after_reset", "ZYBA\r");

    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("model_drained", 32'(exp_q[k].size()), 32'd0);
      chk("frames_drained", 32'(len_q[k].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
